param_stack: RTL and testbench
==============================

# param_stack

Parametrised synchronous LIFO stack: the next generation of the team's 8x8 stack. Width and depth are generic, and every storage and flag update happens on the rising edge of one clock. It adds a replace-top command, an occupancy count, a programmable almost-full flag and a pop-data valid strobe. It sits between a command-issuing controller and any datapath that needs last-in-first-out buffering.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 8, number of entries (>= 2)
- AFULL_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- cmd  input  3  000 nop, 001 clear, 010 push, 011 pop, 100 replace; 101-111 treated as nop
- data_in  input  WIDTH  push/replace data, sampled at rising clk
- data_out  output  WIDTH  registered popped/replaced word
- data_valid  output  1  one-cycle strobe: data_out updated this cycle
- top  output  WIDTH  combinational peek of RAM[count-1]; 0 when empty
- count  output  CW  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_LEVEL
- error  output  1  illegal operation indicator (see Configuration)

## Operation
- Storage: RAM[0..DEPTH-1] holds WIDTH-bit words. Entries occupy indices 0..count-1, and the top of stack is RAM[count-1]. RAM is not reset.
- clear: count <= 0 and error <= 0. RAM is untouched and data_out holds its value.
- push, not full: RAM[count] <= data_in and count <= count+1.
- push, full: no storage or count change; error asserts.
- pop, not empty: data_out <= RAM[count-1], data_valid <= 1, count <= count-1.
- pop, empty: data_out holds, data_valid stays 0, error asserts.
- replace, not empty: data_out <= RAM[count-1], then RAM[count-1] <= data_in. count is unchanged and data_valid <= 1. The old top is returned, never data_in.
- replace, empty: no change; error asserts.
- nop and codes 101-111: no state change except that data_valid returns to 0 and the error behaviour follows Configuration.
- Flags full, empty and almost_full are registered and computed from the next count, so they are always consistent with count on the same cycle.
- Count arithmetic is CW bits wide and never wraps. Overflow and underflow are blocked by the full/empty checks above.

## Timing
- Reset (reset=1 at a rising edge) overrides cmd and sets:
  - count=0, empty=1, full=0, almost_full=0 (1 if AFULL_LEVEL==0 is disallowed, so 0)
  - error=0, data_out=0, data_valid=0
- Reset mid-sequence discards all entries logically. Any cmd on that edge is ignored.
- Command latency is one cycle: a cmd sampled at edge N is reflected in count, flags, data_out and data_valid after edge N.
- top is combinational from count and RAM. It shows the new top immediately after the edge that changed it.
- Back-to-back push/pop on consecutive cycles is supported at full rate with no bubbles.
- Pop on the cycle after a push returns the word just pushed.
- data_valid is high for exactly one cycle per successful pop or replace.

## Configuration
- STACK_STICKY_ERROR_EN defined:
  - error latches high on any illegal push, pop or replace.
  - It stays high until clear or reset.
- STACK_STICKY_ERROR_EN undefined:
  - error is a one-cycle pulse, high only in the cycle after the illegal command.
  - Any legal command or nop deasserts it on the next edge.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 -> count=3, top=0x33, empty=0. Three pops -> data_out 0x33, 0x22, 0x11, each with a one-cycle data_valid; final empty=1, top=0.
- DEPTH=8: push 8 words -> full=1 and almost_full asserted at count 7. A 9th push (0xAA) -> error=1, count stays 8, top unchanged.
- Pop with empty stack -> error=1, data_valid=0, data_out holds its previous value. Then push 0x5A:
  - undefined macro: error=0 after that edge.
  - defined macro: error stays 1 until clear.
- Stack holds [0x01, 0x02]; replace with 0x7F -> data_out=0x02, data_valid=1, count=2, top=0x7F. Next pop -> data_out=0x7F.
- Push 4 words, then assert reset together with a push -> count=0, empty=1, error=0, data_out=0. A following pop -> error.
- Alternating push/pop every cycle for 20 cycles with incrementing data -> each pop returns the immediately preceding pushed value; count toggles 1/0 and no error.

Source files
------------

// File: rtl/param_stack.sv
// param_stack: parametrised synchronous LIFO stack with clear, push, pop and replace commands.
// Optional feature macro: STACK_STICKY_ERROR_EN makes error latch until clear or reset.
module param_stack #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 1,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CMD_NOP     = 3'b000,
    CMD_CLEAR   = 3'b001,
    CMD_PUSH    = 3'b010,
    CMD_POP     = 3'b011,
    CMD_REPLACE = 3'b100
  } cmd_e;

  logic [WIDTH-1:0] ram_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             illegal, clr, wr_en;
  logic [AW-1:0]    wr_addr, top_addr;

  assign top_addr = AW'(count_q - CW'(1));

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    illegal = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = top_addr;
    case (cmd)
      CMD_CLEAR: begin
        count_d = '0;
        clr     = 1'b1;
      end
      CMD_PUSH: begin
        if (full_q) illegal = 1'b1;
        else begin
          wr_en   = 1'b1;
          wr_addr = AW'(count_q);
          count_d = count_q + CW'(1);
        end
      end
      CMD_POP: begin
        if (empty_q) illegal = 1'b1;
        else begin
          dout_d  = ram_q[top_addr];
          valid_d = 1'b1;
          count_d = count_q - CW'(1);
        end
      end
      // Replace reads the old top into data_out while the same edge overwrites it.
      CMD_REPLACE: begin
        if (empty_q) illegal = 1'b1;
        else begin
          dout_d  = ram_q[top_addr];
          valid_d = 1'b1;
          wr_en   = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef STACK_STICKY_ERROR_EN
    error_d = clr ? 1'b0 : (error_q | illegal);
`else
    error_d = illegal;
`endif
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    afull_d = (count_d >= CW'(AFULL_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      error_q <= error_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) ram_q[wr_addr] <= data_in;
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign error       = error_q;
  assign top         = empty_q ? '0 : ram_q[top_addr];

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed scenarios plus randomized traffic
// checked against a queue-based LIFO model.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFULL = 7;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] C_NOP = 3'd0, C_CLR = 3'd1, C_PUSH = 3'd2, C_POP = 3'd3, C_REP = 3'd4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, error;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .top(top), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .error(error)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_err;

`ifdef STACK_STICKY_ERROR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] m_top();
    return (mq.size() != 0) ? mq[mq.size()-1] : '0;
  endfunction

  // Drives one command for one clock and advances the reference model.
  task automatic step(input logic r, input logic [2:0] c, input logic [WIDTH-1:0] d);
    logic bad;
    bad = 1'b0;
    reset = r; cmd = c; data_in = d;
    if (r) begin
      mq.delete(); m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      case (c)
        C_CLR:  begin mq.delete(); m_err = 1'b0; end
        C_PUSH: if (mq.size() == DEPTH) bad = 1'b1; else mq.push_back(d);
        C_POP:  if (mq.size() == 0) bad = 1'b1;
                else begin m_dout = mq.pop_back(); m_valid = 1'b1; end
        C_REP:  if (mq.size() == 0) bad = 1'b1;
                else begin m_dout = mq[mq.size()-1]; mq[mq.size()-1] = d; m_valid = 1'b1; end
        default: ;
      endcase
      if (STICKY) begin
        if (bad) m_err = 1'b1;
      end else m_err = bad;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(1'b1, C_PUSH, 8'h99);
    step(1'b1, C_NOP, 8'h00);
    n_vec++; if (count !== 0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got e%b f%b af%b exp e1 f0 af0", empty, full, almost_full); end
    n_vec++; if (error !== 1'b0 || data_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_err_valid got err%b v%b exp 0 0", error, data_valid); end
    n_vec++; if (data_out !== 8'h00 || top !== 8'h00) begin
      n_err++; $display("FAIL reset_data got dout %h top %h exp 00 00", data_out, top); end
  endtask

  task automatic test_push_pop();
    logic [WIDTH-1:0] exp_d [3];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    step(1'b1, C_NOP, 0);
    step(1'b0, C_PUSH, 8'h11);
    step(1'b0, C_PUSH, 8'h22);
    step(1'b0, C_PUSH, 8'h33);
    n_vec++; if (count !== 3 || top !== 8'h33 || empty !== 1'b0) begin
      n_err++; $display("FAIL push3 got cnt %0d top %h e%b exp 3 33 0", count, top, empty); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, C_POP, 0);
      n_vec++; if (data_out !== exp_d[i] || data_valid !== 1'b1) begin
        n_err++; $display("FAIL pop%0d got dout %h v%b exp %h 1", i, data_out, data_valid, exp_d[i]); end
    end
    step(1'b0, C_NOP, 0);
    n_vec++; if (data_valid !== 1'b0 || empty !== 1'b1 || top !== 8'h00) begin
      n_err++; $display("FAIL pop_end got v%b e%b top %h exp 0 1 00", data_valid, empty, top); end
  endtask

  task automatic test_full();
    step(1'b1, C_NOP, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b0, C_PUSH, 8'(k));
      if (k == 6) begin
        n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL afull_at6 got %b exp 0", almost_full); end
      end else if (k == 7) begin
        n_vec++; if (almost_full !== 1'b1 || full !== 1'b0) begin
          n_err++; $display("FAIL afull_at7 got af%b f%b exp 1 0", almost_full, full); end
      end
    end
    n_vec++; if (full !== 1'b1 || count !== 8) begin
      n_err++; $display("FAIL full_at8 got f%b cnt %0d exp 1 8", full, count); end
    step(1'b0, C_PUSH, 8'hAA);
    n_vec++; if (error !== 1'b1 || count !== 8 || top !== 8'h08) begin
      n_err++; $display("FAIL push_full got err%b cnt %0d top %h exp 1 8 08", error, count, top); end
  endtask

  task automatic test_empty_pop();
    step(1'b1, C_NOP, 0);
    step(1'b0, C_PUSH, 8'h44);
    step(1'b0, C_POP, 0);
    step(1'b0, C_POP, 0);
    n_vec++; if (error !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h44) begin
      n_err++; $display("FAIL pop_empty got err%b v%b dout %h exp 1 0 44", error, data_valid, data_out); end
    step(1'b0, C_PUSH, 8'h5A);
    n_vec++; if (error !== STICKY) begin
      n_err++; $display("FAIL err_after_push got %b exp %b", error, STICKY); end
    step(1'b0, C_CLR, 0);
    n_vec++; if (error !== 1'b0 || count !== 0 || data_out !== 8'h44) begin
      n_err++; $display("FAIL clear got err%b cnt %0d dout %h exp 0 0 44", error, count, data_out); end
  endtask

  task automatic test_replace();
    step(1'b1, C_NOP, 0);
    step(1'b0, C_PUSH, 8'h01);
    step(1'b0, C_PUSH, 8'h02);
    step(1'b0, C_REP, 8'h7F);
    n_vec++; if (data_out !== 8'h02 || data_valid !== 1'b1 || count !== 2 || top !== 8'h7F) begin
      n_err++; $display("FAIL replace got dout %h v%b cnt %0d top %h exp 02 1 2 7f", data_out, data_valid, count, top); end
    step(1'b0, C_POP, 0);
    n_vec++; if (data_out !== 8'h7F) begin n_err++; $display("FAIL pop_after_rep got %h exp 7f", data_out); end
    step(1'b0, C_POP, 0);
    step(1'b0, C_REP, 8'h55);
    n_vec++; if (error !== 1'b1 || data_valid !== 1'b0 || count !== 0) begin
      n_err++; $display("FAIL rep_empty got err%b v%b cnt %0d exp 1 0 0", error, data_valid, count); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, C_NOP, 0);
    for (int k = 0; k < 4; k++) step(1'b0, C_PUSH, 8'(8'hC0 + k));
    step(1'b0, C_POP, 0);
    step(1'b1, C_PUSH, 8'h99);
    n_vec++; if (count !== 0 || empty !== 1'b1 || error !== 1'b0 || data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_mid got cnt %0d e%b err%b dout %h exp 0 1 0 00", count, empty, error, data_out); end
    step(1'b0, C_POP, 0);
    n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL pop_after_reset got err %b exp 1", error); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] last;
    step(1'b1, C_NOP, 0);
    last = '0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        last = 8'(8'h30 + i);
        step(1'b0, C_PUSH, last);
        n_vec++; if (count !== 1 || error !== 1'b0) begin
          n_err++; $display("FAIL b2b_push%0d got cnt %0d err%b exp 1 0", i, count, error); end
      end else begin
        step(1'b0, C_POP, 0);
        n_vec++; if (data_out !== last || count !== 0 || error !== 1'b0 || data_valid !== 1'b1) begin
          n_err++; $display("FAIL b2b_pop%0d got dout %h cnt %0d err%b v%b exp %h 0 0 1",
                            i, data_out, count, error, data_valid, last); end
      end
    end
  endtask

  task automatic test_random();
    int unsigned rr;
    logic [2:0] c;
    logic r;
    step(1'b1, C_NOP, 0);
    for (int i = 0; i < 600; i++) begin
      rr = $urandom_range(0, 99);
      r  = ($urandom_range(0, 79) == 0);
      if (rr < ((i / 100) % 2 == 0 ? 50 : 25))      c = C_PUSH;
      else if (rr < 75)                              c = C_POP;
      else if (rr < 85)                              c = C_REP;
      else if (rr < 89)                              c = C_CLR;
      else if (rr < 94)                              c = C_NOP;
      else                                           c = 3'(5 + $urandom_range(0, 2));
      step(r, c, 8'($urandom));
      n_vec++; if (count !== CW'(mq.size()) || top !== m_top()) begin
        n_err++; $display("FAIL rnd%0d_cnt_top got %0d %h exp %0d %h", i, count, top, mq.size(), m_top()); end
      n_vec++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || almost_full !== (mq.size() >= AFULL)) begin
        n_err++; $display("FAIL rnd%0d_flags got f%b e%b af%b for size %0d", i, full, empty, almost_full, mq.size()); end
      n_vec++; if (data_out !== m_dout || data_valid !== m_valid || error !== m_err) begin
        n_err++; $display("FAIL rnd%0d_out got dout %h v%b err%b exp %h %b %b",
                          i, data_out, data_valid, error, m_dout, m_valid, m_err); end
    end
  endtask

  initial begin
    reset = 1'b1; cmd = C_NOP; data_in = '0;
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_push_pop();
    test_full();
    test_empty_pop();
    test_replace();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
